if_prefetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It generates sequential fetch addresses and drives a variable-latency instruction memory over a req/ack handshake, holding one request in flight at a time. Fetched {pc, code} pairs are buffered in a small FIFO and presented to IF/ID with a valid/ready handshake. A redirect from branch or jump resolution flushes the queue and restarts fetch at the target.

---
 rtl/if_prefetch_queue_if.sv | 37 +++
 rtl/if_prefetch_queue.sv | 166 ++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_if.sv
// rtl/if_prefetch_queue_if.sv - fetch-side memory, redirect and IF/ID handshake bundle
interface if_prefetch_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  mem_req;
    logic [ADR_WIDTH-1:0]  mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  redirect;
    logic [ADR_WIDTH-1:0]  redirect_pc;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_code;
    logic [ADR_WIDTH-1:0]  out_pc;
    logic [ADR_WIDTH-1:0]  out_pc4;
    logic [CW-1:0]         count;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        input  redirect, redirect_pc,
        input  out_ready,
        output out_valid, out_code, out_pc, out_pc4, count
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        output redirect, redirect_pc,
        output out_ready,
        input  out_valid, out_code, out_pc, out_pc4, count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - sequential instruction prefetch queue feeding IF/ID
// Define PREFETCH_BYPASS_EN for a zero-cycle ack-to-output path when the queue is empty.
module if_prefetch_queue #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADR_WIDTH  = 32,
    parameter int                   DEPTH      = 4,
    parameter logic [ADR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                clk,
    input logic                rst,
    if_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t                state;
    logic [ADR_WIDTH-1:0]  fetch_pc;
    logic [ADR_WIDTH-1:0]  mem_addr_q;
    logic                  mem_req_q;

    logic [DATA_WIDTH-1:0] code_mem [DEPTH];
    logic [ADR_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_next;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] code_q;
    logic [ADR_WIDTH-1:0]  pc_q;
    logic [ADR_WIDTH-1:0]  pc4_q;

    logic [ADR_WIDTH-1:0]  target;
    logic [ADR_WIDTH-1:0]  pc_plus4;
    logic                  ack_req;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  credit;
    logic [DATA_WIDTH-1:0] head_code;
    logic [ADR_WIDTH-1:0]  head_pc;

    assign target   = {bus.redirect_pc[ADR_WIDTH-1:2], 2'b00};
    assign pc_plus4 = fetch_pc + ADR_WIDTH'(4);
    assign ack_req  = (state == REQ) && bus.mem_ack;

`ifdef PREFETCH_BYPASS_EN
    assign bypass        = ack_req && !bus.redirect && (count_q == '0);
    assign bus.out_valid = valid_q || bypass;
    assign bus.out_code  = bypass ? bus.mem_rdata : code_q;
    assign bus.out_pc    = bypass ? fetch_pc : pc_q;
    assign bus.out_pc4   = bypass ? pc_plus4 : pc4_q;
`else
    assign bypass        = 1'b0;
    assign bus.out_valid = valid_q;
    assign bus.out_code  = code_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_pc4   = pc4_q;
`endif

    // A bypassed word that IF/ID takes immediately never occupies a slot.
    assign pop         = valid_q && bus.out_ready && !bus.redirect;
    assign push        = ack_req && !bus.redirect && !(bypass && bus.out_ready);
    assign count_next  = bus.redirect ? '0 : count_q + CW'(push) - CW'(pop);
    assign rd_ptr_next = bus.redirect ? '0 : rd_ptr + PW'(pop);
    assign credit      = count_next < CW'(DEPTH);

    // When the new head is the word being written this cycle, take it from the bus.
    assign head_code = (push && count_next == CW'(1)) ? bus.mem_rdata : code_mem[rd_ptr_next];
    assign head_pc   = (push && count_next == CW'(1)) ? fetch_pc      : pc_mem[rd_ptr_next];

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.count    = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc   <= target;
                        mem_addr_q <= target;
                    end else if (credit) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc;
                    end
                end
                REQ: begin
                    if (bus.redirect) begin
                        fetch_pc <= target;
                        if (bus.mem_ack) begin
                            state      <= IDLE;
                            mem_req_q  <= 1'b0;
                            mem_addr_q <= target;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (bus.mem_ack) begin
                        fetch_pc   <= pc_plus4;
                        mem_addr_q <= pc_plus4;
                        if (!credit) begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    // mem_addr keeps the flushed address until its ack arrives.
                    if (bus.redirect) fetch_pc <= target;
                    if (bus.mem_ack) begin
                        state      <= IDLE;
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= bus.redirect ? target : fetch_pc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                code_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            if (push) begin
                code_mem[wr_ptr] <= bus.mem_rdata;
                pc_mem[wr_ptr]   <= fetch_pc;
            end
            wr_ptr  <= bus.redirect ? '0 : wr_ptr + PW'(push);
            rd_ptr  <= rd_ptr_next;
            count_q <= count_next;
            valid_q <= (count_next != '0);
            if (count_next != '0) begin
                code_q <= head_code;
                pc_q   <= head_pc;
                pc4_q  <= head_pc + ADR_WIDTH'(4);
            end else begin
                code_q <= '0;
                pc_q   <= '0;
                pc4_q  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - randomized self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;
    localparam int               DW       = 32;
    localparam int               AW       = 32;
    localparam int               DEPTH    = 4;
    localparam logic [AW-1:0]    RESET_PC = 32'h0000_0000;
    localparam logic [DW-1:0]    CODE_OFS = 32'h2008_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_prefetch_queue_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(
        .DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory: answers each request after lat_min..lat_max cycles, word = CODE_OFS + addr.
    int lat_min = 1;
    int lat_max = 1;
    int wait_cnt;
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = -1;
        forever begin
            @(negedge clk);
            #1;
            if (bus.mem_ack) wait_cnt = -1;
            bus.mem_ack = 1'b0;
            if (rst || !bus.mem_req) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(lat_max, lat_min) - 1;
                if (wait_cnt == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = CODE_OFS + bus.mem_addr;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Reference: the delivered stream is consecutive words from the last restart point.
    logic [AW-1:0] exp_pc = RESET_PC;
    logic [AW-1:0] e_code;
    logic [AW-1:0] e_pc4;
    logic [AW-1:0] addr_prev;
    bit            hold_prev = 1'b0;
    bit            mon_en = 1'b0;
    int            n_pops = 0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (hold_prev) begin
                    chk("addr_stable", bus.mem_addr, addr_prev);
                    chk("req_held", bus.mem_req, 1);
                end
                chk("count_bound", bus.count <= DEPTH, 1);
`ifndef PREFETCH_BYPASS_EN
                chk("valid_vs_count", bus.out_valid, bus.count != 0);
`endif
                if (!bus.out_valid) begin
                    chk("nop_code", bus.out_code, 0);
                    chk("nop_pc", bus.out_pc, 0);
                    chk("nop_pc4", bus.out_pc4, 0);
                end
                if (rst) begin
                    exp_pc = RESET_PC;
                end else if (bus.redirect) begin
                    exp_pc = bus.redirect_pc & ~32'h3;
                end else if (bus.out_valid && bus.out_ready) begin
                    e_code = CODE_OFS + exp_pc;
                    e_pc4  = exp_pc + 32'd4;
                    chk("pop_pc", bus.out_pc, exp_pc);
                    chk("pop_code", bus.out_code, e_code);
                    chk("pop_pc4", bus.out_pc4, e_pc4);
                    exp_pc = e_pc4;
                    n_pops++;
                end
                hold_prev = bus.mem_req && !bus.mem_ack && !rst;
                addr_prev = bus.mem_addr;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_pops=%0d", n_pops);
        $fatal(1);
    end

    task automatic restart(input bit ready);
        @(negedge clk);
        rst           = 1'b1;
        bus.redirect  = 1'b0;
        bus.out_ready = ready;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit            found;
        int            n_ack;
        logic [AW-1:0] pops [4];
        int            npop;
        logic [AW-1:0] first_ack;
        logic [AW-1:0] e;
        int            base;
        int            last_pops;
        int            next_rd;

        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, RESET_PC);
        chk("rst_count", bus.count, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_code", bus.out_code, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_pc4", bus.out_pc4, 0);
        mon_en = 1'b1;

        // Streaming: ack every cycle, out_ready=1
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (bus.mem_req && bus.mem_ack) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t1_ack_seen", found, 1);
        chk("t1_first_addr", bus.mem_addr, RESET_PC);
        chk("t1_valid_at_ack", bus.out_valid, BYP);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #3;
            e = 32'(4 * k) - (BYP ? 32'd0 : 32'd4);
            chk("t1_ack_every", bus.mem_req && bus.mem_ack, 1);
            chk("t1_addr_seq", bus.mem_addr, RESET_PC + 32'(4 * k));
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_out_pc", bus.out_pc, e);
        end

        // Backpressure fills the queue, then drains in order
        restart(1'b0);
        n_ack = 0;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (bus.mem_req && bus.mem_ack) n_ack++;
            @(negedge clk);
        end
        #3;
        chk("t2_acks", n_ack, 4);
        chk("t2_count", bus.count, 4);
        chk("t2_req_off", bus.mem_req, 0);
        chk("t2_head_pc", bus.out_pc, 32'h0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        npop = 0;
        found = 1'b0;
        first_ack = '0;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (bus.out_valid && npop < 4) begin pops[npop] = bus.out_pc; npop++; end
            if (bus.mem_req && bus.mem_ack && !found) begin found = 1'b1; first_ack = bus.mem_addr; end
            @(negedge clk);
        end
        chk("t2_npop", npop, 4);
        for (int j = 0; j < 4; j++) chk("t2_drain_order", pops[j], 32'(4 * j));
        chk("t2_resume_seen", found, 1);
        chk("t2_resume_addr", first_ack, 32'h10);

        // Redirect while the request to 0x8 waits for a slow ack
        lat_min = 4;
        lat_max = 4;
        restart(1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #3;
            if (bus.mem_req && bus.mem_addr == 32'h8) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t3_req8_seen", found, 1);
        chk("t3_no_ack_yet", bus.mem_ack, 0);
        @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0043;
        @(negedge clk);
        bus.redirect = 1'b0;
        #3;
        chk("t3_discard_req", bus.mem_req, 1);
        chk("t3_discard_addr", bus.mem_addr, 32'h8);
        chk("t3_flush_valid", bus.out_valid, 0);
        chk("t3_flush_count", bus.count, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (bus.mem_req && bus.mem_addr != 32'h8) begin found = 1'b1; break; end
        end
        chk("t3_new_req_seen", found, 1);
        chk("t3_new_addr", bus.mem_addr, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin found = 1'b1; break; end
            @(negedge clk);
            #3;
        end
        chk("t3_out_seen", found, 1);
        chk("t3_first_pc", bus.out_pc, 32'h40);

        // Redirect coinciding with an ack while two entries are queued
        lat_min = 1;
        lat_max = 1;
        restart(1'b0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #3;
            if (bus.count == 1 && bus.mem_ack) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t4_setup", found, 1);
        @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        bus.out_ready   = 1'b1;
        #3;
        chk("t4_pre_count", bus.count, 2);
        chk("t4_pre_ack", bus.mem_ack, 1);
        @(negedge clk);
        bus.redirect = 1'b0;
        #3;
        chk("t4_count", bus.count, 0);
        chk("t4_valid", bus.out_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (bus.out_valid) begin found = 1'b1; break; end
        end
        chk("t4_out_seen", found, 1);
        chk("t4_first_pc", bus.out_pc, 32'h100);

        // Reset mid-request with three entries queued
        lat_min = 3;
        lat_max = 3;
        restart(1'b0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (bus.count == 3 && bus.mem_req && !bus.mem_ack) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t5_setup", found, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("t5_req", bus.mem_req, 0);
        chk("t5_count", bus.count, 0);
        chk("t5_code", bus.out_code, 0);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_addr", bus.mem_addr, RESET_PC);
        lat_min = 1;
        lat_max = 1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (bus.mem_req && bus.mem_ack) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t5_restart_seen", found, 1);
        chk("t5_restart_addr", bus.mem_addr, RESET_PC);

        // Random latency, random backpressure, periodic redirects
        lat_min = 1;
        lat_max = 5;
        restart(1'b1);
        base      = n_pops;
        last_pops = n_pops;
        next_rd   = $urandom_range(44, 30);
        for (int cyc = 0; cyc < 40000 && (n_pops - base) < 1000; cyc++) begin
            bus.redirect  = 1'b0;
            bus.out_ready = ($urandom_range(3, 0) != 0);
            if (n_pops - last_pops >= next_rd) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = $urandom;
                last_pops       = n_pops;
                next_rd         = $urandom_range(44, 30);
            end else if ($urandom_range(199, 0) == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = $urandom;
            end
            @(negedge clk);
        end
        bus.redirect = 1'b0;
        chk("t6_completed", (n_pops - base) >= 1000, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
